// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types for the multicycle control unit of the 4-bit-opcode core:
//   opcode_e  - instruction opcodes (IR opcode field, low 4 bits)
//   alu_op_e  - ALU operation codes driven on alu_inst during EXEC
//   state_e   - control FSM states
//   op_to_alu - maps a decoded opcode plus the IR mode bit to an ALU op
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_LB   = 4'h0, OP_LHB = 4'h1, OP_JMP = 4'h2, OP_STR  = 4'h3,
    OP_LIM  = 4'h4, OP_MVB = 4'h5, OP_MVF = 4'h6, OP_ADD  = 4'h7,
    OP_SUB  = 4'h8, OP_SFT = 4'h9, OP_BNE = 4'hA, OP_BEQ  = 4'hB,
    OP_BLT  = 4'hC, OP_INC = 4'hD, OP_HALT = 4'hE, OP_TBA = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_SFL = 4'h2, ALU_SFR = 4'h3,
    ALU_INC = 4'h4, ALU_DEC = 4'h5, ALU_BNE = 4'h6, ALU_BEQ = 4'h7,
    ALU_BLT = 4'h8
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_FAULT
  } state_e;

  // Opcodes without a dedicated ALU function (loads, stores, moves, jumps)
  // use ADD, which is also the address/pass-through operation.
  function automatic alu_op_e op_to_alu(opcode_e op, logic imm);
    alu_op_e res;
    res = ALU_ADD;
    case (op)
      OP_SUB: res = ALU_SUB;
      OP_SFT: res = imm ? ALU_SFR : ALU_SFL;
      OP_INC: res = imm ? ALU_INC : ALU_DEC;
      OP_BNE: res = ALU_BNE;
      OP_BEQ: res = ALU_BEQ;
      OP_BLT: res = ALU_BLT;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundles the control unit's run/halt, IR, memory and strobe signals.
//   master modport: the control unit (drives strobes, mem_req, status)
//   slave  modport: the surrounding datapath / memory / sequencer
// Handshakes:
//   mem_req/mem_ack - mem_req rises and stays high until a clock edge on which
//   mem_ack=1; that edge completes the transfer. mem_ack while mem_req=0 has
//   no effect. run is a one-cycle pulse honoured only while the unit is IDLE.
// dbg_state exposes the FSM state for observation.
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16
) ();
  import cpu_ctrl_pkg::*;

  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                imm_flag;
  logic                mem_ack;
  logic                mem_req;
  logic                mem_we;
  logic                ir_load;
  logic                pc_inc;
  logic                pc_load;
  logic                branch_en;
  logic [ALU_OP_W-1:0] alu_inst;
  logic                write_reg;
  logic                busy;
  logic                halted;
  logic                fault;
  logic [CNT_W-1:0]    retired_count;
  state_e              dbg_state;

  modport master (
    input  run, opcode, imm_flag, mem_ack,
    output mem_req, mem_we, ir_load, pc_inc, pc_load, branch_en, alu_inst,
           write_reg, busy, halted, fault, retired_count, dbg_state
  );

  modport slave (
    output run, opcode, imm_flag, mem_ack,
    input  mem_req, mem_we, ir_load, pc_inc, pc_load, branch_en, alu_inst,
           write_reg, busy, halted, fault, retired_count, dbg_state
  );

endinterface

// File: rtl/multicycle_control_mem_timeout_ctr.sv
// -----------------------------------------------------------------------------
// mem_timeout_ctr
// Counts consecutive cycles a memory request waits without acknowledge.
//   clk, reset  - clock, asynchronous active-high reset
//   i_clear     - zero the counter (no request pending, or request completed)
//   i_enable    - request pending and not acknowledged this cycle
//   o_expired   - this cycle is the MEM_TIMEOUT-th unacknowledged one
// MEM_TIMEOUT=0 removes the counter and never expires.
// -----------------------------------------------------------------------------
module mem_timeout_ctr #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(MEM_TIMEOUT + 1);
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_cnt <= '0;
        else if (i_clear)  r_cnt <= '0;
        else if (i_enable) r_cnt <= r_cnt + 1'b1;
      end

      // r_cnt holds the number of earlier waiting cycles, so the limit is
      // reached on the cycle where it equals MEM_TIMEOUT-1.
      assign o_expired = i_enable && (r_cnt == CW'(MEM_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Sequenced control unit: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] per
// instruction, with a run/halt handshake, memory-timeout fault and a
// retired-instruction counter.
//   clk    - clock
//   reset  - asynchronous active-high reset
//   bus    - multicycle_control_if.master (run, opcode, imm_flag, mem_ack in;
//            mem_req, mem_we, strobes, alu_inst, status, retired_count out)
// Optional: define CONTROL_TRACE_EN to print one line per state entry.
// -----------------------------------------------------------------------------
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_e              r_state;
  state_e              w_next;
  logic [OPCODE_W-1:0] r_op;
  logic                r_imm;
  logic [CNT_W-1:0]    r_retired;

  opcode_e             w_dec;
  logic                w_op_valid;
  logic                w_retire;
  logic                w_mem_req, w_mem_we, w_ir_load, w_pc_inc, w_pc_load;
  logic                w_branch_en, w_write_reg;
  logic [ALU_OP_W-1:0] w_alu_inst;
  logic                w_tmo_expired;

  // Opcode values with any bit set above the low nibble act as NOP.
  generate
    if (OPCODE_W > 4) begin : g_wide_op
      assign w_op_valid = (r_op[OPCODE_W-1:4] == '0);
    end else begin : g_narrow_op
      assign w_op_valid = 1'b1;
    end
  endgenerate

  // NOP behaves like TBA: retire without side effects.
  assign w_dec = w_op_valid ? opcode_e'(r_op[3:0]) : OP_TBA;

  mem_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (!w_mem_req || bus.mem_ack),
    .i_enable  (w_mem_req && !bus.mem_ack),
    .o_expired (w_tmo_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_imm     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op  <= bus.opcode;
        r_imm <= bus.imm_flag;
      end
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_ir_load   = 1'b0;
    w_pc_inc    = 1'b0;
    w_pc_load   = 1'b0;
    w_branch_en = 1'b0;
    w_alu_inst  = '0;
    w_write_reg = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.run) w_next = S_FETCH;
      S_FETCH: begin
        w_mem_req = 1'b1;
        // An ack on the limit cycle takes priority over the timeout.
        if (bus.mem_ack) begin
          w_ir_load = 1'b1;
          w_pc_inc  = 1'b1;
          w_next    = S_DECODE;
        end else if (w_tmo_expired) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        w_alu_inst = ALU_OP_W'(op_to_alu(w_dec, r_imm));
        case (w_dec)
          OP_ADD, OP_SUB, OP_SFT, OP_INC, OP_LIM, OP_MVB, OP_MVF: w_next = S_WB;
          OP_LB, OP_LHB, OP_STR: w_next = S_MEM;
          OP_BNE, OP_BEQ, OP_BLT: begin
            w_branch_en = 1'b1;
            w_retire    = 1'b1;
            w_next      = S_FETCH;
          end
          OP_JMP: begin
            w_pc_load = 1'b1;
            w_retire  = 1'b1;
            w_next    = S_FETCH;
          end
          OP_HALT: begin
            w_retire = 1'b1;
            w_next   = S_HALTED;
          end
          default: begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (w_dec == OP_STR);
        if (bus.mem_ack) begin
          if (w_dec == OP_STR) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_tmo_expired) begin
          w_next = S_FAULT;
        end
      end
      S_WB: begin
        w_write_reg = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_HALTED, S_FAULT: w_next = r_state;
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.mem_req       = w_mem_req;
  assign bus.mem_we        = w_mem_we;
  assign bus.ir_load       = w_ir_load;
  assign bus.pc_inc        = w_pc_inc;
  assign bus.pc_load       = w_pc_load;
  assign bus.branch_en     = w_branch_en;
  assign bus.alu_inst      = w_alu_inst;
  assign bus.write_reg     = w_write_reg;
  assign bus.busy          = !(r_state inside {S_IDLE, S_HALTED, S_FAULT});
  assign bus.halted        = (r_state == S_HALTED);
  assign bus.fault         = (r_state == S_FAULT);
  assign bus.retired_count = r_retired;
  assign bus.dbg_state     = r_state;

`ifdef CONTROL_TRACE_EN
  always @(posedge clk) begin
    if (!reset && (w_next != r_state))
      $display("[trace] state=%s op=%s retired=%0d",
               w_next.name(), w_dec.name(), r_retired + CNT_W'(w_retire));
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control. Two instances share clock/reset:
// u_dut (CNT_W=16) for the main sequences and u_dut2 (CNT_W=2) for the
// retired-count wrap. Inputs change 1 time unit after a rising edge and
// outputs are sampled 1 unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control;
  import cpu_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  multicycle_control_if #(.OPCODE_W(4), .ALU_OP_W(4), .CNT_W(16)) bus ();
  multicycle_control_if #(.OPCODE_W(4), .ALU_OP_W(4), .CNT_W(2))  bus2 ();

  multicycle_control #(.OPCODE_W(4), .ALU_OP_W(4), .MEM_TIMEOUT(15), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  multicycle_control #(.OPCODE_W(4), .ALU_OP_W(4), .MEM_TIMEOUT(15), .CNT_W(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.master)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.run = 1'b0;  bus.mem_ack = 1'b0;  bus.opcode = '0;  bus.imm_flag = 1'b0;
    bus2.run = 1'b0; bus2.mem_ack = 1'b0; bus2.opcode = '0; bus2.imm_flag = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    #1;
  endtask

  // start: drive run for one cycle; returns 2 units into cycle 1 (FETCH)
  task automatic start(input opcode_e op, input logic imm, input logic ack);
    bus.opcode = op; bus.imm_flag = imm; bus.mem_ack = ack; bus.run = 1'b1;
    cyc();
    bus.run = 1'b0;
    #1;
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b1;

    // 1. reset state, then ADD with ack tied high
    do_reset();
    chk("rst_state",    bus.dbg_state, S_IDLE);
    chk("rst_mem_req",  bus.mem_req, 0);
    chk("rst_busy",     bus.busy, 0);
    chk("rst_retired",  bus.retired_count, 0);
    start(OP_ADD, 1'b0, 1'b1);                 // cycle 1
    chk("add_c1_ir_load", bus.ir_load, 1);
    chk("add_c1_pc_inc",  bus.pc_inc, 1);
    chk("add_c1_mem_req", bus.mem_req, 1);
    cyc(2);                                    // cycle 3
    chk("add_c3_state", bus.dbg_state, S_EXEC);
    chk("add_c3_alu",   bus.alu_inst, ALU_ADD);
    cyc();                                     // cycle 4
    chk("add_c4_write_reg", bus.write_reg, 1);
    cyc();                                     // cycle 5
    chk("add_c5_retired", bus.retired_count, 1);
    chk("add_c5_write_reg", bus.write_reg, 0);

    // 2. SFT with imm=1 then imm=0; opcode only sampled in DECODE
    do_reset();
    start(OP_SFT, 1'b1, 1'b1);
    cyc(2);                                    // cycle 3 EXEC
    chk("sft_imm1_alu", bus.alu_inst, ALU_SFR);
    cyc();                                     // cycle 4 WB
    bus.imm_flag = 1'b0;
    cyc(3);                                    // cycle 7 EXEC
    bus.opcode = OP_JMP; bus.imm_flag = 1'b1;
    #1;
    chk("sft_imm0_state", bus.dbg_state, S_EXEC);
    chk("sft_imm0_alu",   bus.alu_inst, ALU_SFL);
    chk("sft_imm0_pc_load", bus.pc_load, 0);

    // 3. BEQ then JMP, 3 cycles each
    do_reset();
    start(OP_BEQ, 1'b0, 1'b1);
    cyc(2);                                    // cycle 3 EXEC
    chk("beq_branch_en", bus.branch_en, 1);
    chk("beq_alu",       bus.alu_inst, ALU_BEQ);
    bus.opcode = OP_JMP;
    bus.run = 1'b1;                            // ignored while busy
    cyc();                                     // cycle 4 FETCH
    bus.run = 1'b0;
    #1;
    chk("beq_retired", bus.retired_count, 1);
    chk("beq_c4_state", bus.dbg_state, S_FETCH);
    cyc(2);                                    // cycle 6 EXEC
    chk("jmp_pc_load",   bus.pc_load, 1);
    chk("jmp_branch_en", bus.branch_en, 0);
    cyc();                                     // cycle 7
    chk("jmp_retired", bus.retired_count, 2);

    // 4. STR with ack delayed 3 cycles in MEM
    do_reset();
    start(OP_STR, 1'b0, 1'b1);                 // cycle 1
    cyc();                                     // cycle 2
    bus.mem_ack = 1'b0;
    cyc();                                     // cycle 3 EXEC
    chk("str_exec_mem_req", bus.mem_req, 0);
    for (int i = 4; i <= 6; i++) begin
      cyc();
      chk($sformatf("str_c%0d_mem_req", i), bus.mem_req, 1);
      chk($sformatf("str_c%0d_mem_we", i),  bus.mem_we, 1);
    end
    cyc();                                     // cycle 7, ack arrives
    bus.mem_ack = 1'b1;
    #1;
    chk("str_c7_mem_we",    bus.mem_we, 1);
    chk("str_c7_write_reg", bus.write_reg, 0);
    cyc();                                     // cycle 8
    bus.mem_ack = 1'b0;
    #1;
    chk("str_c8_state",     bus.dbg_state, S_FETCH);
    chk("str_c8_mem_we",    bus.mem_we, 0);
    chk("str_c8_write_reg", bus.write_reg, 0);
    chk("str_c8_retired",   bus.retired_count, 1);

    // 5. fetch never acknowledged -> FAULT after 15 request cycles
    do_reset();
    start(OP_ADD, 1'b0, 1'b0);                 // cycle 1
    cyc(14);                                   // cycle 15
    chk("tmo_c15_mem_req", bus.mem_req, 1);
    chk("tmo_c15_fault",   bus.fault, 0);
    cyc();                                     // cycle 16
    chk("tmo_c16_fault",   bus.fault, 1);
    chk("tmo_c16_mem_req", bus.mem_req, 0);
    chk("tmo_c16_busy",    bus.busy, 0);
    bus.run = 1'b1; bus.mem_ack = 1'b1;
    cyc(3);
    bus.run = 1'b0;
    chk("tmo_sticky_fault", bus.fault, 1);
    chk("tmo_sticky_state", bus.dbg_state, S_FAULT);
    chk("tmo_sticky_req",   bus.mem_req, 0);
    chk("tmo_retired",      bus.retired_count, 0);

    // 6. ack on the limit cycle wins over the timeout
    do_reset();
    start(OP_ADD, 1'b0, 1'b0);
    cyc(14);                                   // cycle 15
    bus.mem_ack = 1'b1;
    #1;
    chk("tmo_edge_ir_load", bus.ir_load, 1);
    cyc();
    chk("tmo_edge_state", bus.dbg_state, S_DECODE);
    chk("tmo_edge_fault", bus.fault, 0);

    // 7. LB latency, then reset in the middle of the next LB's MEM
    do_reset();
    start(OP_LB, 1'b0, 1'b1);
    cyc(3);                                    // cycle 4 MEM
    chk("lb_c4_mem_req", bus.mem_req, 1);
    chk("lb_c4_mem_we",  bus.mem_we, 0);
    cyc();                                     // cycle 5 WB
    chk("lb_c5_write_reg", bus.write_reg, 1);
    cyc();                                     // cycle 6 FETCH
    chk("lb_c6_retired", bus.retired_count, 1);
    cyc();                                     // cycle 7 DECODE
    bus.mem_ack = 1'b0;
    cyc(2);                                    // cycle 9 MEM waiting
    chk("lb_c9_state", bus.dbg_state, S_MEM);
    reset = 1'b1;
    #1;
    chk("lb_rst_mem_req", bus.mem_req, 0);
    chk("lb_rst_state",   bus.dbg_state, S_IDLE);
    chk("lb_rst_busy",    bus.busy, 0);
    chk("lb_rst_retired", bus.retired_count, 0);
    cyc();
    reset = 1'b0;

    // 8. three ADDs then HALT
    do_reset();
    start(OP_ADD, 1'b0, 1'b1);                 // cycle 1
    cyc(11);                                   // cycle 12 WB of third ADD
    bus.opcode = OP_HALT;
    cyc();                                     // cycle 13
    chk("halt_c13_retired", bus.retired_count, 3);
    cyc(2);                                    // cycle 15 EXEC
    chk("halt_c15_halted", bus.halted, 0);
    cyc();                                     // cycle 16
    chk("halt_halted",  bus.halted, 1);
    chk("halt_busy",    bus.busy, 0);
    chk("halt_mem_req", bus.mem_req, 0);
    chk("halt_retired", bus.retired_count, 4);
    bus.run = 1'b1;
    cyc();
    bus.run = 1'b0;
    cyc(2);
    chk("halt_run_state",   bus.dbg_state, S_HALTED);
    chk("halt_run_retired", bus.retired_count, 4);

    // 9. CNT_W=2: five branches wrap the count to 1
    do_reset();
    bus2.opcode = OP_BEQ; bus2.mem_ack = 1'b1; bus2.run = 1'b1;
    cyc();                                     // cycle 1
    bus2.run = 1'b0;
    cyc(12);                                   // cycle 13, four retired
    chk("wrap_c13_retired", bus2.retired_count, 0);
    cyc(3);                                    // cycle 16, five retired
    chk("wrap_c16_retired", bus2.retired_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequenced, parametrised control unit for the 4-bit-opcode core; replaces single-cycle combinational decode.
- FSM walks each instruction through FETCH, DECODE, EXEC, MEM and WB with a memory req/ack handshake.
- Emits per-phase strobes to PC, IR, ALU, register file and data memory.
- Adds a run/halt handshake, a memory timeout fault and a retired-instruction counter.

Parameters:
- OPCODE_W, 4, opcode field width; opcode values below occupy the low 4 bits, others decode as NOP.
- ALU_OP_W, 4, width of alu_inst.
- MEM_TIMEOUT, 15, max cycles mem_req may stay unacknowledged; 0 disables the timeout.
- CNT_W, 16, width of retired_count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  single-cycle start pulse, honoured only in IDLE.
- opcode  in  OPCODE_W  IR opcode field, valid from the DECODE cycle onward.
- imm_flag  in  1  IR immediate/mode bit.
- mem_ack  in  1  memory completes the current request; sampled at clk edge while mem_req=1.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write qualifier for mem_req (store only).
- ir_load  out  1  one-cycle strobe: IR captures memory read data.
- pc_inc  out  1  one-cycle strobe: PC += 1.
- pc_load  out  1  one-cycle strobe: PC takes the jump target.
- branch_en  out  1  one-cycle strobe: PC takes the target if the ALU compare is true.
- alu_inst  out  ALU_OP_W  ALU operation, valid in EXEC; 0 elsewhere.
- write_reg  out  1  one-cycle register-file write strobe.
- busy  out  1  high in every state except IDLE, HALTED and FAULT.
- halted  out  1  high in HALTED.
- fault  out  1  high in FAULT, sticky until reset.
- retired_count  out  CNT_W  instructions completed since reset, wraps.

Behaviour:
- Reset: state=IDLE, all outputs 0, timeout counter 0, retired_count 0. Applies immediately, including mid-FETCH or mid-MEM; mem_req drops asynchronously.
- Opcodes: LB=0, LHB=1, JMP=2, STR=3, LIM=4, MVB=5, MVF=6, ADD=7, SUB=8, SFT=9, BNE=A, BEQ=B, BLT=C, INC=D, HALT=E, TBA=F.
- ALU ops: ADD=0, SUB=1, SFL=2, SFR=3, INC=4, DEC=5, BNE=6, BEQ=7, BLT=8.
- IDLE:
  - run=1 -> FETCH.
- FETCH:
  - mem_req=1, mem_we=0.
  - On an edge with mem_ack=1: ir_load=1 and pc_inc=1 in that cycle -> DECODE.
- DECODE (1 cycle):
  - Register {opcode, imm_flag}; later states use only the registered copy.
  - -> EXEC.
- EXEC (1 cycle):
  - alu_inst from the registered opcode: SFT uses imm_flag ? SFR : SFL; INC uses imm_flag ? INC : DEC.
  - ADD/SUB/SFT/INC/LIM/MVB/MVF -> WB.
  - LB/LHB/STR -> MEM.
  - BNE/BEQ/BLT: branch_en=1, retire -> FETCH.
  - JMP: pc_load=1, retire -> FETCH.
  - TBA: retire -> FETCH.
  - HALT: retire -> HALTED.
- MEM:
  - mem_req=1; mem_we=1 only for STR.
  - On ack: STR retires -> FETCH; LB/LHB -> WB.
- WB:
  - write_reg=1 for one cycle, retire -> FETCH.
- HALTED:
  - Stays until reset; run is ignored.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 without ack.
  - If it reaches MEM_TIMEOUT with no ack -> FAULT: mem_req=0, fault=1, absorbing.
  - An ack on the same edge that the limit is hit wins (completes normally).
- Handshake rules:
  - mem_ack while mem_req=0 is ignored.
  - run while busy is ignored.
- Retire:
  - retired_count increments by 1 on the completing edge and wraps at 2^CNT_W.
- Latency with mem_ack tied high:
  - ALU op 4 cycles; LB 5; STR 4; branch/JMP 3.
  - Each wait cycle adds 1.

Optional Feature:
- CONTROL_TRACE_EN defined: on every state entry, $display one line of state name, mnemonic and retired_count. No effect on outputs or timing.
- Undefined: no $display statements are compiled; RTL is otherwise identical.

Decomposition:
- Package cpu_ctrl_pkg: opcode enum, ALU-op enum, FSM state enum, and function op_to_alu(opcode, imm_flag) returning the ALU op.
- Sub-module mem_timeout_ctr (clear/enable inputs, expired output) holds the counter and the MEM_TIMEOUT=0 bypass.

Test Plan:
- Reset, run pulse, ack tied 1, opcode=ADD:
  - ir_load/pc_inc at cycle 1, alu_inst=0 at cycle 3, write_reg at cycle 4.
  - retired_count=1.
- Run, opcode=SFT with imm_flag=1 and then 0:
  - alu_inst=3 and then 2 in EXEC.
- STR with mem_ack delayed 3 cycles:
  - mem_req held with mem_we=1 for 4 cycles, no write_reg, back in FETCH.
- No ack, MEM_TIMEOUT=15:
  - fault=1 after 15 req cycles, mem_req=0, busy=0; later run and mem_ack have no effect.
- Reset asserted mid-MEM of LB:
  - all outputs 0 immediately, state IDLE, retired_count=0.
- HALT after 3 ADDs:
  - halted=1, retired_count=4; run pulse ignored; CNT_W=2 run of 5 instructions wraps the count to 1.
